fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, imem request and a one-entry skid buffer toward if_2_rf.
// Optional perf counters (fetch_cnt, stall_cnt) are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_br_taken,
  input  logic [63:0] i_br_target,
  output logic        o_imem_req,
  output logic [63:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_rdata,
  output logic [63:0] o_pc_out,
  output logic [31:0] o_instr_out,
  output logic        o_valid_out,
  output logic [63:0] o_pc_plus4_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_stall_cnt
`endif
);

  // state | meaning
  // BOOT  | one idle cycle after reset, no request
  // FETCH | requesting imem at pc, delivering when downstream accepts
  // HOLD  | word parked in skid buffer, waiting for stall to drop
  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]  r_state;
  logic [63:0] r_pc;
  logic [63:0] r_pc_out;
  logic [31:0] r_instr_out;
  logic        r_valid_out;
  logic [31:0] r_skid_data;

  logic [1:0]  w_state_nxt;
  logic [63:0] w_pc_nxt;
  logic        w_load;
  logic [31:0] w_load_instr;
  logic        w_bubble;
  logic        w_skid_cap;
  logic        w_valid_nxt;
  logic        w_deliver;
  logic        w_unused_tgt_lsb;

  assign w_unused_tgt_lsb = ^i_br_target[1:0];

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_load       = 1'b0;
    w_load_instr = i_imem_rdata;
    w_bubble     = 1'b0;
    w_skid_cap   = 1'b0;
    if (i_br_taken) begin
      w_state_nxt = S_FETCH;
      w_pc_nxt    = {i_br_target[63:2], 2'b00};
      w_bubble    = 1'b1;
    end else begin
      case (r_state)
        S_BOOT: w_state_nxt = S_FETCH;
        S_FETCH: begin
          if (!i_stall) begin
            if (i_imem_ready) begin
              w_load   = 1'b1;
              w_pc_nxt = r_pc + 64'd4;
            end else begin
              w_bubble = 1'b1;
            end
          end else if (i_imem_ready) begin
            w_skid_cap  = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!i_stall) begin
            w_load       = 1'b1;
            w_load_instr = r_skid_data;
            w_pc_nxt     = r_pc + 64'd4;
            w_state_nxt  = S_FETCH;
          end
        end
        default: w_state_nxt = S_BOOT;
      endcase
    end
  end

  // flush squashes whatever lands on the output, but pc/skid still advance normally
  always_comb begin
    w_valid_nxt = r_valid_out;
    if (i_br_taken || i_flush) w_valid_nxt = 1'b0;
    else if (w_load)           w_valid_nxt = 1'b1;
    else if (w_bubble)         w_valid_nxt = 1'b0;
  end

  assign w_deliver = w_load & ~i_flush & ~i_br_taken;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_BOOT;
      r_pc        <= RESET_PC;
      r_pc_out    <= 64'd0;
      r_instr_out <= 32'd0;
      r_valid_out <= 1'b0;
      r_skid_data <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_valid_out <= w_valid_nxt;
      if (w_load) begin
        r_pc_out    <= r_pc;
        r_instr_out <= w_load_instr;
      end
      if (w_skid_cap) r_skid_data <= i_imem_rdata;
    end
  end

  assign o_imem_req     = (r_state == S_FETCH);
  assign o_imem_addr    = r_pc;
  assign o_pc_out       = r_pc_out;
  assign o_instr_out    = r_instr_out;
  assign o_valid_out    = r_valid_out;
  assign o_pc_plus4_out = r_pc_out + 64'd4;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_deliver && (r_fetch_cnt != 32'hFFFF_FFFF))
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (i_stall && r_valid_out && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_stall_cnt = r_stall_cnt;
`else
  logic w_unused_deliver;
  assign w_unused_deliver = w_deliver;
`endif

endmodule
